// File: rtl/uart_rx_core_if.sv
// -----------------------------------------------------------------------------
// uart_rx_core_if
// Consumer-side handshake between the UART receive engine and the APB slave
// that reads it.
//   data_read      consumer -> core  1-cycle pulse, rx_data has been read
//   rx_data        core -> consumer  received word, right-justified
//   data_ready     core -> consumer  unread word present in rx_data
//   overrun_error  core -> consumer  a word was overwritten before being read
//   framing_error  core -> consumer  last frame had a 0 stop bit
//   parity_error   core -> consumer  only when UART_RX_PARITY_EN is defined
// Modports: slave = receive core, master = register-side consumer.
// -----------------------------------------------------------------------------
interface uart_rx_core_if;
  logic       data_read;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       overrun_error;
  logic       framing_error;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
`endif

  modport slave (
    input  data_read,
    output rx_data, data_ready, overrun_error, framing_error
`ifdef UART_RX_PARITY_EN
    , output parity_error
`endif
  );

  modport master (
    output data_read,
    input  rx_data, data_ready, overrun_error, framing_error
`ifdef UART_RX_PARITY_EN
    , input parity_error
`endif
  );
endinterface

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// Serial receive engine: synchronises an async idle-high line, detects the
// start edge, samples each bit at its centre and hands the word to the
// consumer with data_ready / overrun_error / framing_error status.
// Frame: 1 start (0), n data bits LSB first (n = 5..8), optional even parity,
// 1 stop (1). Bit timing and width are latched at the start edge.
// Optional feature: define UART_RX_PARITY_EN to add the even-parity bit and
// the parity_error output.
// Parameters:
//   SYNC_STAGES  flops in the serial_in synchroniser (>= 2)
//   MIN_PERIOD   smallest bit period accepted; lower values are clamped
// Ports:
//   clk          system clock
//   n_rst        asynchronous active-low reset
//   serial_in    async serial line, idle high
//   bit_period   clocks per bit
//   data_size    data bits per frame, 5..8 (anything else means 8)
//   bus          uart_rx_core_if.slave consumer handshake and status
// -----------------------------------------------------------------------------
module uart_rx_core #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PERIOD  = 10
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          serial_in,
  input  logic [13:0]   bit_period,
  input  logic [3:0]    data_size,
  uart_rx_core_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    LOAD
  } state_e;

  localparam logic [13:0] MIN_BP = 14'(MIN_PERIOD);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_dly_q;
  logic [13:0]            timer_q, timer_d;
  logic [13:0]            bp_q, bp_d;
  logic [3:0]             nbits_q, nbits_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   data_ready_q, data_ready_d;
  logic                   overrun_q, overrun_d;
  logic                   framing_q, framing_d;
`ifdef UART_RX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  logic        line;
  logic        fall;
  logic        tick;
  logic [13:0] bp_eff;
  logic [3:0]  n_eff;

  assign line   = sync_q[SYNC_STAGES-1];
  assign fall   = sync_dly_q & ~line;
  assign tick   = (timer_q == 14'd0);
  assign bp_eff = (bit_period < MIN_BP) ? MIN_BP : bit_period;
  assign n_eff  = (data_size >= 4'd5 && data_size <= 4'd8) ? data_size : 4'd8;

  // Synchroniser and registered state. The synchroniser resets to 1 so that
  // leaving reset never looks like a start edge on the idle-high line.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync_q       <= '1;
      sync_dly_q   <= 1'b1;
      state_q      <= IDLE;
      timer_q      <= '0;
      bp_q         <= MIN_BP;
      nbits_q      <= 4'd8;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      data_ready_q <= 1'b0;
      overrun_q    <= 1'b0;
      framing_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // the synchroniser chain would collapse to one stage with blocking ones.
      sync_q       <= {sync_q[SYNC_STAGES-2:0], serial_in};
      sync_dly_q   <= line;
      state_q      <= state_d;
      timer_q      <= timer_d;
      bp_q         <= bp_d;
      nbits_q      <= nbits_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      data_ready_q <= data_ready_d;
      overrun_q    <= overrun_d;
      framing_q    <= framing_d;
`ifdef UART_RX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d      = state_q;
    timer_d      = tick ? timer_q : timer_q - 14'd1;
    bp_d         = bp_q;
    nbits_d      = nbits_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    data_ready_d = data_ready_q;
    overrun_d    = overrun_q;
    framing_d    = framing_q;
`ifdef UART_RX_PARITY_EN
    parity_d     = parity_q;
`endif

    // Consumer read; LOAD below overrides it when both land in one cycle.
    if (bus.data_read) begin
      data_ready_d = 1'b0;
      overrun_d    = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (fall) begin
          bp_d    = bp_eff;
          nbits_d = n_eff;
          // First sample lands half a bit after the edge.
          timer_d = (bp_eff >> 1) - 14'd1;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (line) begin
            state_d = IDLE;
          end else begin
            framing_d = 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_d  = 1'b0;
`endif
            shift_d   = '0;
            bit_cnt_d = '0;
            timer_d   = bp_q - 14'd1;
            state_d   = DATA;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_d[bit_cnt_q] = line;
          timer_d            = bp_q - 14'd1;
          if ((4'(bit_cnt_q) + 4'd1) == nbits_q) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          // Even parity: data ones plus the parity bit must be even.
          parity_d = (^shift_q) ^ line;
          timer_d  = bp_q - 14'd1;
          state_d  = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (!line) begin
            framing_d = 1'b1;
            state_d   = IDLE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        rx_data_d    = shift_q;
        data_ready_d = 1'b1;
        overrun_d    = bus.data_read ? 1'b0 : (overrun_q | data_ready_q);
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.data_ready    = data_ready_q;
  assign bus.overrun_error = overrun_q;
  assign bus.framing_error = framing_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_error  = parity_q;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
// Self-checking bench for uart_rx_core. Frames are generated bit by bit on
// serial_in; expected status comes from a frame-level model of the receiver
// (what each complete frame and each read does to the visible outputs).
// Build with +define+UART_RX_PARITY_EN to cover the parity variant.
// -----------------------------------------------------------------------------
module tb_uart_rx_core;
  localparam int SYNC = 2;
  localparam int MINP = 10;
`ifdef UART_RX_PARITY_EN
  localparam int PBIT = 1;
`else
  localparam int PBIT = 0;
`endif

  logic        clk = 1'b0;
  logic        n_rst;
  logic        serial_in;
  logic [13:0] bit_period;
  logic [3:0]  data_size;

  uart_rx_core_if bus_if ();

  uart_rx_core #(.SYNC_STAGES(SYNC), .MIN_PERIOD(MINP)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .serial_in  (serial_in),
    .bit_period (bit_period),
    .data_size  (data_size),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level reference state: what the consumer should currently see.
  logic [7:0] m_data;
  logic       m_ready, m_over, m_frame, m_par;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".rx_data"},       32'(bus_if.rx_data),       32'(m_data));
    check({tag, ".data_ready"},    32'(bus_if.data_ready),    32'(m_ready));
    check({tag, ".overrun_error"}, 32'(bus_if.overrun_error), 32'(m_over));
    check({tag, ".framing_error"}, 32'(bus_if.framing_error), 32'(m_frame));
`ifdef UART_RX_PARITY_EN
    check({tag, ".parity_error"},  32'(bus_if.parity_error),  32'(m_par));
`endif
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_ready = 1'b0; m_over = 1'b0; m_frame = 1'b0; m_par = 1'b0;
  endtask

  task automatic model_read();
    m_ready = 1'b0;
    m_over  = 1'b0;
  endtask

  function automatic int eff_bp(input int cfg);
    return (cfg < MINP) ? MINP : cfg;
  endfunction

  function automatic int eff_n(input int cfg);
    return (cfg >= 5 && cfg <= 8) ? cfg : 8;
  endfunction

  // All drives happen 1 time unit after a rising edge.
  task automatic idle(input int cycles);
    serial_in = 1'b1;
    repeat (cycles) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic read_pulse();
    bus_if.data_read = 1'b1;
    @(posedge clk); #1;
    bus_if.data_read = 1'b0;
    model_read();
    @(posedge clk); #1;
  endtask

  // Sends one frame and updates the model. lat = index of the edge (0 = first
  // edge that sees the start bit) after which data_ready rose, or -1.
  task automatic run_frame(input logic [7:0] word, input int ds_cfg, input int bp_cfg,
                           input logic stop_bit, input logic par_bad,
                           input logic rd_in_load, input logic scramble,
                           output int lat);
    int         n, bp, total, read_cyc;
    logic [7:0] mask, masked;
    logic       par, prev;
    logic       b[$];
    n        = eff_n(ds_cfg);
    bp       = eff_bp(bp_cfg);
    mask     = 8'((1 << n) - 1);
    masked   = word & mask;
    par      = (^masked) ^ par_bad;
    total    = (n + 2 + PBIT) * bp;
    read_cyc = rd_in_load ? (SYNC + bp / 2 + (n + 1 + PBIT) * bp + 1) : -1;
    b.push_back(1'b0);
    for (int i = 0; i < n; i++) b.push_back(word[i]);
    if (PBIT == 1) b.push_back(par);
    b.push_back(stop_bit);
    bit_period = 14'(bp_cfg);
    data_size  = 4'(ds_cfg);
    prev = bus_if.data_ready;
    lat  = -1;
    for (int cyc = 0; cyc < total; cyc++) begin
      serial_in        = b[cyc / bp];
      bus_if.data_read = (cyc == read_cyc);
      // Config is latched at the start edge; later changes must be ignored.
      if (scramble && cyc == bp) begin
        bit_period = 14'($urandom_range(0, 40));
        data_size  = 4'($urandom);
      end
      @(posedge clk); #1;
      if (lat < 0 && bus_if.data_ready && !prev) lat = cyc;
      prev = bus_if.data_ready;
    end
    bus_if.data_read = 1'b0;
    serial_in        = 1'b1;
    m_frame = 1'b0;
    m_par   = (PBIT == 1) ? par_bad : 1'b0;
    if (!stop_bit) begin
      m_frame = 1'b1;
      if (rd_in_load) model_read();
    end else begin
      m_over  = rd_in_load ? 1'b0 : (m_over | m_ready);
      m_ready = 1'b1;
      m_data  = masked;
    end
    idle(4);
  endtask

  initial begin
    int lat;
    n_rst            = 1'b0;
    serial_in        = 1'b1;
    bit_period       = 14'd10;
    data_size        = 4'd8;
    bus_if.data_read = 1'b0;
    model_reset();
    #1;
    check_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    n_rst = 1'b1;
    idle(3);

    // Basic 8-bit frame and pin-to-data_ready latency.
    run_frame(8'hA5, 8, 10, 1'b1, 1'b0, 1'b0, 1'b0, lat);
    check("a5.latency", 32'(lat), 32'(SYNC + 96));
    check_outputs("a5");
    read_pulse();
    check_outputs("a5.read");

    // 5-bit frame, upper bits must read back 0.
    run_frame(8'hFB, 5, 10, 1'b1, 1'b0, 1'b0, 1'b0, lat);
    check("size5.data", 32'(bus_if.rx_data), 32'h1B);
    check_outputs("size5");
    read_pulse();

    // Overrun: two frames without a read, then one read clears both flags.
    run_frame(8'h11, 8, 10, 1'b1, 1'b0, 1'b0, 1'b0, lat);
    run_frame(8'h22, 8, 10, 1'b1, 1'b0, 1'b0, 1'b0, lat);
    check("overrun.flag", 32'(bus_if.overrun_error), 32'd1);
    check_outputs("overrun");
    read_pulse();
    check_outputs("overrun.read");

    // Framing error keeps the previous unread word; the next good frame,
    // read in its LOAD cycle, clears framing_error without setting overrun.
    run_frame(8'h55, 8, 10, 1'b1, 1'b0, 1'b0, 1'b0, lat);
    run_frame(8'h3C, 8, 10, 1'b0, 1'b0, 1'b0, 1'b0, lat);
    check("framing.flag", 32'(bus_if.framing_error), 32'd1);
    check_outputs("framing");
    run_frame(8'h66, 8, 10, 1'b1, 1'b0, 1'b1, 1'b0, lat);
    check_outputs("framing.recover");
    read_pulse();

    // 3-cycle glitch at bp=20 is a false start.
    run_frame(8'h81, 8, 10, 1'b1, 1'b0, 1'b0, 1'b0, lat);
    bit_period = 14'd20;
    serial_in  = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    idle(40);
    check_outputs("glitch");
    run_frame(8'h5A, 8, 20, 1'b1, 1'b0, 1'b0, 1'b0, lat);
    check_outputs("glitch.next");
    read_pulse();

    // Too-small bit_period is clamped to MIN_PERIOD.
    run_frame(8'hC3, 8, 4, 1'b1, 1'b0, 1'b0, 1'b0, lat);
    check("clamp.latency", 32'(lat), 32'(SYNC + 96));
    check_outputs("clamp");
    read_pulse();

`ifdef UART_RX_PARITY_EN
    run_frame(8'h07, 8, 10, 1'b1, 1'b1, 1'b0, 1'b0, lat);
    check("parity.flag", 32'(bus_if.parity_error), 32'd1);
    check_outputs("parity.bad");
    run_frame(8'h07, 8, 10, 1'b1, 1'b0, 1'b1, 1'b0, lat);
    check_outputs("parity.good");
    read_pulse();
`endif

    // Randomised frames: sizes, periods, stop errors, reads and mid-frame
    // config changes.
    for (int i = 0; i < 24; i++) begin
      logic [7:0] w;
      logic       stop_ok, par_bad, rd_load, scr;
      w       = 8'($urandom);
      stop_ok = ($urandom_range(0, 4) != 0);
      par_bad = ($urandom_range(0, 3) == 0);
      rd_load = ($urandom_range(0, 5) == 0);
      scr     = ($urandom_range(0, 1) == 1);
      run_frame(w, $urandom_range(0, 15), $urandom_range(0, 24), stop_ok, par_bad,
                rd_load, scr, lat);
      check_outputs("random");
      if ($urandom_range(0, 1) == 1) begin
        read_pulse();
        check_outputs("random.read");
      end
    end

    // Reset in the middle of DATA with an unread word pending.
    run_frame(8'h99, 8, 10, 1'b1, 1'b0, 1'b0, 1'b0, lat);
    bit_period = 14'd10;
    data_size  = 4'd8;
    serial_in  = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
    end
    n_rst = 1'b0;
    #1;
    model_reset();
    check_outputs("midreset");
    serial_in = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    n_rst = 1'b1;
    idle(5);
    check_outputs("midreset.release");
    run_frame(8'h42, 8, 10, 1'b1, 1'b0, 1'b0, 1'b0, lat);
    check_outputs("midreset.next");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
